// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator divider.
package calc_pkg;

    // Controller states: idle/accept, one quotient bit per CALC cycle, sign fix-up.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Default operand widths used by the calculator datapath.
    localparam int DEF_DW = 16;
    localparam int DEF_VW = 8;

    // Fill bit for the divide-by-zero quotient; replicated to DW bits gives all ones.
    localparam logic DZ_Q_FILL = 1'b1;

endpackage

// File: rtl/calc_abs.sv
// Conditional two's-complement negate: out = neg_en ? -in : in.
module calc_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] in,
    input  logic         neg_en,
    output logic [W-1:0] out
);

    // Negate when enabled; the most-negative value maps onto itself as an unsigned magnitude.
    always_comb begin
        out = neg_en ? -in : in;
    end

endmodule

// File: rtl/calc_div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned.
// Handshake: start is accepted only while busy is low (IDLE, which includes the
// done cycle); done pulses for one cycle and q/r/neg/dz/ovf are valid from that
// cycle and held until the next done.
module calc_div_seq
    import calc_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          signed_mode,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          neg,
    output logic          dz,
    output logic          ovf,
    output logic [1:0]    dbg_state
);

    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_INIT = CW'(DW - 1);

    state_e          state_q, state_d;
    logic            sa_q, sb_q, zero_q, ovf_pend_q;
    logic [DW-1:0]   amag_q, qmag_q;
    logic [VW-1:0]   bmag_q;
    logic [VW:0]     part_q;
    logic [CW-1:0]   cnt_q;

    logic [DW-1:0]   q_q, q_d;
    logic [VW-1:0]   r_q, r_d;
    logic            neg_q, neg_d, dz_q, dz_d, ovf_q, ovf_d, done_q;

    logic            load_op, step, finish;
    logic [DW-1:0]   amag_in, q_fix;
    logic [VW-1:0]   bmag_in, r_fix;
    logic [VW:0]     shifted, diff, part_d;
    logic            ge;

    calc_abs #(.W(DW)) u_abs_a (.in(a),              .neg_en(signed_mode & a[DW-1]), .out(amag_in));
    calc_abs #(.W(VW)) u_abs_b (.in(b),              .neg_en(signed_mode & b[VW-1]), .out(bmag_in));
    calc_abs #(.W(DW)) u_fix_q (.in(qmag_q),         .neg_en(sa_q ^ sb_q),           .out(q_fix));
    calc_abs #(.W(VW)) u_fix_r (.in(part_q[VW-1:0]), .neg_en(sa_q),                  .out(r_fix));

    // One restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        shifted = (part_q << 1) | {{VW{1'b0}}, amag_q[cnt_q]};
        diff    = shifted - {1'b0, bmag_q};
        ge      = (shifted >= {1'b0, bmag_q});
        part_d  = ge ? diff : shifted;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: a zero divisor skips the iteration entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (b == '0) ? ST_FIX : ST_CALC;
            ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: datapath controls and the final result values written in FIX.
    always_comb begin
        busy    = (state_q != ST_IDLE);
        load_op = (state_q == ST_IDLE) && start;
        step    = (state_q == ST_CALC);
        finish  = (state_q == ST_FIX);
        q_d     = q_fix;
        r_d     = r_fix;
        neg_d   = (sa_q ^ sb_q) & (qmag_q != '0);
        dz_d    = 1'b0;
        ovf_d   = ovf_pend_q;
        if (zero_q) begin
            q_d   = {DW{DZ_Q_FILL}};
            r_d   = '0;
            neg_d = 1'b0;
            dz_d  = 1'b1;
            ovf_d = 1'b0;
        end
    end

    // Operand capture on accept, then one quotient bit per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            zero_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            amag_q     <= '0;
            bmag_q     <= '0;
            part_q     <= '0;
            qmag_q     <= '0;
            cnt_q      <= '0;
        end else if (load_op) begin
            sa_q       <= signed_mode & a[DW-1];
            sb_q       <= signed_mode & b[VW-1];
            zero_q     <= (b == '0);
            ovf_pend_q <= signed_mode & (a == {1'b1, {(DW-1){1'b0}}}) & (b == '1);
            amag_q     <= amag_in;
            bmag_q     <= bmag_in;
            part_q     <= '0;
            qmag_q     <= '0;
            cnt_q      <= CNT_INIT;
        end else if (step) begin
            part_q     <= part_d;
            qmag_q     <= {qmag_q[DW-2:0], ge};
            cnt_q      <= cnt_q - CW'(1);
        end
    end

    // Result registers: loaded together in FIX, held otherwise; done is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            r_q    <= '0;
            neg_q  <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                q_q   <= q_d;
                r_q   <= r_d;
                neg_q <= neg_d;
                dz_q  <= dz_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign done      = done_q;
    assign q         = q_q;
    assign r         = r_q;
    assign neg       = neg_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_div_seq.sv
// Bench for calc_div_seq (DW=16, VW=8): directed vectors, arithmetic reference model,
// per-cycle output compare against a scoreboard queue.
module tb_calc_div_seq;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        neg;
        logic        dz;
        logic        ovf;
    } res_t;

    typedef struct {
        logic        sm;
        logic [15:0] a;
        logic [7:0]  b;
        res_t        res;
    } vec_t;

    logic        clk, rst_n, start, signed_mode;
    logic [15:0] a;
    logic [7:0]  b;
    logic        busy, done, neg, dz, ovf;
    logic [15:0] q;
    logic [7:0]  r;
    logic [1:0]  dbg_state;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t last_res = '0;
    vec_t vt[13];

    calc_div_seq #(.DW(16), .VW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r),
        .neg(neg), .dz(dz), .ovf(ovf), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: plain integer division, truncating toward zero.
    function automatic res_t model(input logic sm, input logic [15:0] av_i, input logic [7:0] bv_i);
        res_t   res;
        longint av, bv, qv, rv;
        av = sm ? longint'($signed(av_i)) : longint'(av_i);
        bv = sm ? longint'($signed(bv_i)) : longint'(bv_i);
        res = '0;
        if (bv == 0) begin
            res.q  = 16'hFFFF;
            res.dz = 1'b1;
        end else begin
            qv      = av / bv;
            rv      = av % bv;
            res.q   = qv[15:0];
            res.r   = rv[7:0];
            res.neg = (qv != 0) && ((av < 0) != (bv < 0));
            res.ovf = sm && (av_i == 16'h8000) && (bv_i == 8'hFF);
        end
        return res;
    endfunction

    // Scoreboard compare: every cycle the outputs must equal the most recent completed result.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_res = '0;
            chk("done_in_reset", {31'd0, done}, 32'd0);
        end else if (done) begin
            if (exp_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
            else last_res = exp_q.pop_front();
        end
        chk("outputs", {5'd0, q, r, neg, dz, ovf}, {5'd0, last_res});
    end

    // Driver: call at a negedge while the DUT is idle; returns at the negedge of the done cycle.
    task automatic do_div(input logic sm, input logic [15:0] av, input logic [7:0] bv, input int poke_at);
        int n;
        int lat;
        lat = (bv == 8'd0) ? 1 : 17;
        exp_q.push_back(model(sm, av, bv));
        signed_mode = sm;
        a           = av;
        b           = bv;
        start       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start       = 1'b0;
            signed_mode = 1'($urandom_range(0, 1));
            a           = 16'($urandom_range(0, 65535));
            b           = 8'($urandom_range(0, 255));
            if (poke_at != 0 && n == poke_at) start = 1'b1;
            if (!done) chk("busy_during_op", {31'd0, busy}, 32'd1);
        end while (!done && n < 60);
        start = 1'b0;
        chk("done_latency", n, lat + 1);
        if (done) chk("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic reset_mid_calc();
        signed_mode = 1'b0;
        a           = 16'd1000;
        b           = 8'd7;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("busy_after_abort", {31'd0, busy}, 32'd0);
        chk("state_after_abort", {30'd0, dbg_state}, 32'd0);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        vt[0]  = '{1'b0, 16'd1000, 8'd7,   '{16'd142,   8'd6,   1'b0, 1'b0, 1'b0}};
        vt[1]  = '{1'b1, 16'hFC18, 8'h07,  '{16'hFF72,  8'hFA,  1'b1, 1'b0, 1'b0}};
        vt[2]  = '{1'b1, 16'h03E8, 8'hF9,  '{16'hFF72,  8'h06,  1'b1, 1'b0, 1'b0}};
        vt[3]  = '{1'b1, 16'hFC18, 8'hF9,  '{16'h008E,  8'hFA,  1'b0, 1'b0, 1'b0}};
        vt[4]  = '{1'b0, 16'h1234, 8'h00,  '{16'hFFFF,  8'h00,  1'b0, 1'b1, 1'b0}};
        vt[5]  = '{1'b1, 16'h8000, 8'hFF,  '{16'h8000,  8'h00,  1'b0, 1'b0, 1'b1}};
        vt[6]  = '{1'b0, 16'h8000, 8'hFF,  '{16'h0080,  8'h80,  1'b0, 1'b0, 1'b0}};
        vt[7]  = '{1'b0, 16'hFFFF, 8'hFF,  '{16'h0101,  8'h00,  1'b0, 1'b0, 1'b0}};
        vt[8]  = '{1'b1, 16'hFFFF, 8'h02,  '{16'h0000,  8'hFF,  1'b0, 1'b0, 1'b0}};
        vt[9]  = '{1'b1, 16'h0005, 8'hFE,  '{16'hFFFE,  8'h01,  1'b1, 1'b0, 1'b0}};
        vt[10] = '{1'b0, 16'h0003, 8'hC8,  '{16'h0000,  8'h03,  1'b0, 1'b0, 1'b0}};
        vt[11] = '{1'b1, 16'h8000, 8'h80,  '{16'h0100,  8'h00,  1'b0, 1'b0, 1'b0}};
        vt[12] = '{1'b1, 16'h1234, 8'h00,  '{16'hFFFF,  8'h00,  1'b0, 1'b1, 1'b0}};

        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, 32'd0);
        #2 rst_n = 1'b1;

        // Pin the model against the hand-computed table.
        for (int i = 0; i < 13; i++)
            chk($sformatf("model_vec%0d", i), {5'd0, model(vt[i].sm, vt[i].a, vt[i].b)}, {5'd0, vt[i].res});

        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            do_div(vt[i].sm, vt[i].a, vt[i].b, 0);
            chk($sformatf("dut_vec%0d", i), {5'd0, q, r, neg, dz, ovf}, {5'd0, vt[i].res});
            if (i % 3 == 1) repeat (2) @(negedge clk);
        end

        // A start pulse mid-computation must be ignored.
        repeat (2) @(negedge clk);
        do_div(1'b0, 16'd1000, 8'd7, 5);
        chk("poke_q", {16'd0, q}, 32'd142);
        chk("poke_r", {24'd0, r}, 32'd6);
        repeat (3) @(negedge clk);
        chk("poke_no_restart", {31'd0, busy}, 32'd0);

        // Reset mid-computation aborts; a fresh divide then completes.
        reset_mid_calc();
        do_div(1'b0, 16'd1000, 8'd7, 0);
        chk("after_reset_q", {16'd0, q}, 32'd142);
        chk("after_reset_r", {24'd0, r}, 32'd6);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_div_seq.md
# calc_div_seq

Parametrised, multi-cycle signed/unsigned integer divider for the calculator datapath. Replaces the combinational divider with a restoring shift-subtract engine that produces one quotient bit per clock, with a start/done handshake so the calculator controller can issue a divide and wait. Returns a true two's-complement quotient and remainder, and flags divide-by-zero and signed overflow.

## Interface
- DW, 16, dividend and quotient width (≥ 2)
- VW, 8, divisor and remainder width (2 ≤ VW ≤ DW)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- signed_mode  in  1  1 = operands two's complement, 0 = unsigned; sampled with start
- a  in  DW  dividend; sampled with start
- b  in  VW  divisor; sampled with start
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse; results valid from this cycle
- q  out  DW  quotient, held until the next done
- r  out  VW  remainder, held until the next done
- neg  out  1  quotient is negative (signed_mode, signs differ, magnitude ≠ 0)
- dz  out  1  divisor was zero
- ovf  out  1  signed most-negative / −1

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: on start=1, latch sa = signed_mode & a[DW-1] and sb = signed_mode & b[VW-1]; latch |a| and |b| as unsigned magnitudes (negated when sa/sb); clear the partial remainder; set bit counter = DW-1. Next state is CALC, or FIX directly if b == 0.
- CALC: shift the next dividend magnitude bit (MSB first) into the partial remainder, which is VW+1 bits wide. If partial ≥ |b|, subtract |b| and set the quotient bit to 1, else set it to 0. Decrement the counter. After the bit-0 iteration, go to FIX. Exactly DW iterations.
- FIX, normal case:
  - q = (sa^sb) ? −qmag : qmag, truncated to DW bits.
  - r = sa ? −rmag : rmag. The remainder sign follows the dividend.
  - neg = (sa^sb) & (qmag ≠ 0).
  - ovf = signed_mode & a == 100…0 & b == all-ones. q then wraps to 100…0 and r = 0.
- FIX, b == 0: q = all ones, r = 0, neg = 0, dz = 1, ovf = 0.
- FIX writes q, r, neg, dz and ovf together, pulses done, and returns to IDLE.
- start while busy is ignored. Inputs are not re-sampled mid-operation.
- Unsigned mode: sa = sb = 0, so ovf and neg are always 0.

## Timing
- Reset (async assert): state IDLE; busy, done, q, r, neg, dz, ovf all 0.
- Start sampled at edge E0. busy is high from after E0 until the edge that asserts done.
- Normal case: outputs and done update at edge E(DW+1), so done is high in the cycle after that edge (17 edges for DW=16).
- b == 0: done updates at edge E1.
- done is high for exactly one cycle. A start sampled in the done cycle is accepted (state is IDLE), giving back-to-back operation.
- rst_n low mid-CALC aborts the operation and clears all outputs. No done is issued.

## Structure
- Package calc_pkg holds:
  - state encoding constants (IDLE/CALC/FIX)
  - default DW/VW values
  - the divide-by-zero quotient constant (all ones)
- Sub-module calc_abs(W): combinational conditional two's-complement negate (in, neg_en → out). Used for the |a| and |b| magnitudes and the q/r sign fix.
- Counter width is $clog2(DW).

## Test plan
All cases use DW=16, VW=8.
- Unsigned 1000 / 7 → q=142, r=6, neg=0, dz=0, done 17 edges after start.
- Signed −1000 (0xFC18) / 7 → q=0xFF72, r=0xFA, neg=1.
- Signed 1000 / −7 → q=0xFF72, r=0x06, neg=1. Signed −1000 / −7 → q=0x008E, r=0xFA, neg=0.
- b=0 (a=0x1234) → dz=1, q=0xFFFF, r=0, done 1 edge after start.
- Signed 0x8000 / 0xFF → ovf=1, q=0x8000, r=0. The same operands unsigned → q=0x0080, r=0x80, ovf=0.
- start pulsed mid-CALC → ignored, first result intact. rst_n low mid-CALC → all outputs 0 with no done, then a new 1000/7 completes correctly.
